// File: rtl/key_step_conditioner.sv
// Pushbutton conditioner: synchronises and debounces an active-low key and emits
// one-cycle step pulses (with optional auto-repeat) plus the mode captured at each step.
//
// state        | meaning
// S_IDLE       | key released and debounced
// S_DB_PRESS   | key seen pressed, waiting for it to stay stable
// S_HELD       | press accepted, counting towards the first auto-repeat
// S_REPEAT     | auto-repeating every REPEAT_PERIOD cycles
// S_DB_RELEASE | key seen released, waiting for it to stay stable
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_n,
  input  logic [1:0] mode_in,
  input  logic       repeat_en,
  output logic       step,
  output logic [1:0] step_mode,
  output logic       key_down
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_DB_PRESS   = 3'd1;
  localparam logic [2:0] S_HELD       = 3'd2;
  localparam logic [2:0] S_REPEAT     = 3'd3;
  localparam logic [2:0] S_DB_RELEASE = 3'd4;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             key_meta_q, key_meta_d;
  logic             key_sync_q, key_sync_d;
  logic [1:0]       mode_meta_q, mode_meta_d;
  logic [1:0]       mode_sync_q, mode_sync_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic [1:0]       step_mode_q, step_mode_d;
  logic             key_down_q, key_down_d;
  logic             key_p;
  logic             fire;

  always_comb begin
    key_meta_d  = key_n;
    key_sync_d  = key_meta_q;
    mode_meta_d = mode_in;
    mode_sync_d = mode_meta_q;
    key_p       = ~key_sync_q;

    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = 1'b0;
    step_mode_d = step_mode_q;
    fire        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_p) state_d = S_DB_PRESS;
      end
      S_DB_PRESS: begin
        if (!key_p) begin
          state_d = S_IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_HELD;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HELD: begin
        if (!key_p) begin
          state_d = S_DB_RELEASE;
        end else if (repeat_en && (cnt_q == RD_LAST)) begin
          state_d = S_REPEAT;
          fire    = 1'b1;
        end else if (cnt_q != RD_LAST) begin
          // Saturate so a late repeat_en starts repeating on the very next edge.
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REPEAT: begin
        if (!key_p) begin
          state_d = S_DB_RELEASE;
        end else if (!repeat_en) begin
          state_d = S_HELD;
        end else if (cnt_q == RP_LAST) begin
          fire  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DB_RELEASE: begin
        if (key_p) begin
          state_d = S_HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    if (fire) begin
      step_d      = 1'b1;
      step_mode_d = mode_sync_q;
    end

    key_down_d = (state_d == S_HELD) || (state_d == S_REPEAT) ||
                 (state_d == S_DB_RELEASE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_meta_q  <= 1'b1;
      key_sync_q  <= 1'b1;
      mode_meta_q <= 2'b00;
      mode_sync_q <= 2'b00;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      step_q      <= 1'b0;
      step_mode_q <= 2'b00;
      key_down_q  <= 1'b0;
    end else begin
      key_meta_q  <= key_meta_d;
      key_sync_q  <= key_sync_d;
      mode_meta_q <= mode_meta_d;
      mode_sync_q <= mode_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      step_mode_q <= step_mode_d;
      key_down_q  <= key_down_d;
    end
  end

  assign step      = step_q;
  assign step_mode = step_mode_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Directed bench for key_step_conditioner: expected step events are queued at
// stimulus time and matched against the DUT's step/step_mode output.
module tb_key_step_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic [1:0] mode_in = 2'b00;
  logic       repeat_en = 1'b0;
  logic       step;
  logic [1:0] step_mode;
  logic       key_down;

  key_step_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (8)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .key_n    (key_n),
    .mode_in  (mode_in),
    .repeat_en(repeat_en),
    .step     (step),
    .step_mode(step_mode),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
  } exp_t;

  exp_t       exp_q[$];
  int         ecnt = 0;
  int         total = 0;
  int         bad = 0;
  logic       mon_on = 1'b0;
  logic       rst_at_edge = 1'b1;
  logic [1:0] exp_mode = 2'b00;
  logic       step_prev = 1'b0;
  logic       due;
  exp_t       mon_e;

  always @(posedge clk) begin
    ecnt        <= ecnt + 1;
    rst_at_edge <= reset;
  end

  // Scoreboard: every step must line up with the oldest queued event.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_at_edge) exp_mode = 2'b00;
      due = (exp_q.size() > 0) && (exp_q[0].cyc <= ecnt);
      if (due || step === 1'b1) begin
        total++;
        assert (step === due)
        else begin
          bad++;
          $error("FAIL step_event edge=%0d observed=%b expected=%b", ecnt, step, due);
        end
        if (due) begin
          mon_e    = exp_q.pop_front();
          exp_mode = mon_e.mode;
        end
      end
      total++;
      assert (!(step === 1'b1 && step_prev === 1'b1))
      else begin
        bad++;
        $error("FAIL step_twice edge=%0d observed=11 expected=not both", ecnt);
      end
      total++;
      assert (step_mode === exp_mode)
      else begin
        bad++;
        $error("FAIL step_mode edge=%0d observed=%b expected=%b", ecnt, step_mode, exp_mode);
      end
      step_prev = step;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic at(input int k);
    while (ecnt < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int c, input logic [1:0] m);
    exp_t e;
    e.cyc  = c;
    e.mode = m;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, ecnt, obs, expv);
    end
  endtask

  int base;
  int rb;
  int k;

  initial begin
    // Reset state
    at(3);
    chk("rst_step", {1'b0, step}, 2'b00);
    chk("rst_step_mode", step_mode, 2'b00);
    chk("rst_key_down", {1'b0, key_down}, 2'b00);
    reset  = 1'b0;
    mon_on = 1'b1;

    // Single press, no repeat; mode changes while held must not leak out
    at(ecnt + 2);
    base    = ecnt;
    key_n   = 1'b0;
    mode_in = 2'b01;
    push(base + DB + 3, 2'b01);
    at(base + 6);
    chk("press_kd_before", {1'b0, key_down}, 2'b00);
    at(base + 7);
    chk("press_kd_after", {1'b0, key_down}, 2'b01);
    chk("press_step", {1'b0, step}, 2'b01);
    at(base + 10);
    mode_in = 2'b11;
    at(base + 27);
    rb    = ecnt;
    key_n = 1'b1;
    at(rb + 6);
    chk("rel_kd_before", {1'b0, key_down}, 2'b01);
    at(rb + 7);
    chk("rel_kd_after", {1'b0, key_down}, 2'b00);

    // Short glitch: three low cycles are rejected
    at(ecnt + 3);
    base  = ecnt;
    key_n = 1'b0;
    at(base + 3);
    key_n = 1'b1;
    at(base + 6);
    chk("glitch_kd_mid", {1'b0, key_down}, 2'b00);
    at(base + 12);
    chk("glitch_kd_end", {1'b0, key_down}, 2'b00);

    // Auto-repeat: steps at +7, +17, +20, +23; mode change lands on +23 only
    at(ecnt + 3);
    base      = ecnt;
    key_n     = 1'b0;
    mode_in   = 2'b01;
    repeat_en = 1'b1;
    push(base + 7, 2'b01);
    push(base + 17, 2'b01);
    push(base + 20, 2'b01);
    push(base + 23, 2'b11);
    at(base + 20);
    mode_in = 2'b11;
    at(base + 22);
    chk("rep_mode_hold", step_mode, 2'b01);
    at(base + 23);
    rb    = ecnt;
    key_n = 1'b1;
    at(rb + 6);
    chk("rep_rel_kd_before", {1'b0, key_down}, 2'b01);
    at(rb + 7);
    chk("rep_rel_kd_after", {1'b0, key_down}, 2'b00);

    // Release bounce, then late repeat_en after saturation
    repeat_en = 1'b0;
    at(ecnt + 3);
    base    = ecnt;
    key_n   = 1'b0;
    mode_in = 2'b10;
    push(base + 7, 2'b10);
    at(base + 9);
    rb    = ecnt;
    key_n = 1'b1;
    at(rb + 2);
    key_n = 1'b0;
    at(rb + 3);
    chk("bounce_kd_a", {1'b0, key_down}, 2'b01);
    at(rb + 4);
    chk("bounce_kd_b", {1'b0, key_down}, 2'b01);
    at(rb + 6);
    chk("bounce_kd_c", {1'b0, key_down}, 2'b01);
    at(rb + 20);
    k         = ecnt;
    repeat_en = 1'b1;
    push(k + 1, 2'b10);
    push(k + 4, 2'b10);
    at(k + 5);
    repeat_en = 1'b0;
    at(k + 8);
    rb    = ecnt;
    key_n = 1'b1;
    at(rb + 6);
    chk("late_rel_kd_before", {1'b0, key_down}, 2'b01);
    at(rb + 7);
    chk("late_rel_kd_after", {1'b0, key_down}, 2'b00);

    // Reset pulse during the press debounce
    at(ecnt + 3);
    base  = ecnt;
    key_n = 1'b0;
    at(base + 4);
    reset = 1'b1;
    at(base + 5);
    chk("midrst_step", {1'b0, step}, 2'b00);
    chk("midrst_kd", {1'b0, key_down}, 2'b00);
    chk("midrst_step_mode", step_mode, 2'b00);
    reset = 1'b0;
    rb    = ecnt;
    push(rb + 7, 2'b10);
    at(rb + 6);
    chk("midrst_kd_before", {1'b0, key_down}, 2'b00);
    at(rb + 7);
    chk("midrst_kd_after", {1'b0, key_down}, 2'b01);
    at(rb + 10);
    key_n = 1'b1;
    at(ecnt + 10);

    total++;
    assert (exp_q.size() == 0)
    else begin
      bad++;
      $error("FAIL pending_steps observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_step_conditioner.md
Name: key_step_conditioner

Overview:
- Input conditioner that sits directly upstream of the 2-bit up/down counter.
- Takes the raw active-low pushbutton and the raw mode switches, synchronises and debounces them, and emits a clean single-cycle step pulse with a stable captured mode.
- Optional auto-repeat while the button is held.
- The downstream counter advances on the step pulse in the system clock domain instead of clocking directly from the button.

Parameters:
- DEBOUNCE_CYCLES, 250000: cycles of stable level required to accept a press or a release (5 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000: cycles from the accepted press to the first auto-repeat step; must be >= 2.
- REPEAT_PERIOD, 5000000: cycles between successive auto-repeat steps; must be >= 2.
- CNT_W, 25: width of the shared cycle counter; must hold max(parameter) - 1.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset; top level drives it from SW[17].
- key_n  in  1  raw pushbutton (KEY[0]); active-low; asynchronous to the clock.
- mode_in  in  2  raw mode switches (SW[1:0]); asynchronous.
- repeat_en  in  1  1 = auto-repeat enabled while held; already synchronous.
- step  out  1  one-cycle pulse per accepted press and per repeat.
- step_mode  out  2  mode_in (synchronised) captured on the same edge that raises step; held until the next step.
- key_down  out  1  debounced button level (1 = pressed).

Behaviour:
- Reset values: step=0, step_mode=00, key_down=0, state=IDLE, cnt=0.
  - Synchronisers reset to key_n=1 (released) and mode=00.
- Reset dominates every other event on the same edge.
- Synchronisers: two-flop chain on key_n and on each mode_in bit. key_p = ~key_sync.
- FSM states: IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE. cnt is cleared on every state transition.
- IDLE:
  - key_p=1 -> DB_PRESS.
- DB_PRESS:
  - key_p=0 -> IDLE (glitch rejected, no step).
  - Else if cnt==DEBOUNCE_CYCLES-1 -> HELD, with step<=1 and step_mode<=mode_sync.
  - Else cnt++.
- HELD:
  - key_p=0 -> DB_RELEASE.
  - Else if repeat_en and cnt==REPEAT_DELAY-1 -> REPEAT, with step<=1 and step_mode<=mode_sync.
  - Else cnt++, saturating at REPEAT_DELAY-1.
- REPEAT:
  - key_p=0 -> DB_RELEASE.
  - Else if repeat_en=0 -> HELD.
  - Else if cnt==REPEAT_PERIOD-1 -> step<=1, step_mode<=mode_sync, cnt<=0, stay in REPEAT.
  - Else cnt++.
- DB_RELEASE:
  - key_p=1 -> HELD (release bounce; no step, repeat delay restarts).
  - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE.
  - Else cnt++.
- key_down: registered; 1 exactly while state is HELD, REPEAT or DB_RELEASE.
- step:
  - Registered; high for exactly one cycle per event.
  - Cleared on every edge that does not raise it.
  - Never high on two consecutive cycles.
- Latency: key_n held low from before edge 1 -> step high after edge DEBOUNCE_CYCLES+3, low after the next edge.
- Auto-repeat timing:
  - First repeat step follows the press step by REPEAT_DELAY cycles.
  - Later repeat steps are spaced REPEAT_PERIOD cycles apart.
- repeat_en raised while in HELD after cnt has saturated -> REPEAT entered on the next edge, with a step.
- Changes to mode_in between steps never alter step_mode.
- Reset asserted mid-press: no step while reset is high. After reset falls with the key still held, the full synchroniser and debounce sequence reruns from IDLE.

Test Plan:
- DEBOUNCE_CYCLES=4, key_n driven low before edge 1 and held, repeat_en=0, mode_in=01 -> step high only after edge 7; step_mode=01; key_down=1 after edge 7; no further step.
- Same setup, key_n low for 3 cycles then high -> step never asserts, key_down stays 0, FSM returns to IDLE.
- DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, repeat_en=1, key held -> steps after edges 7, 17, 20, 23; release -> key_down falls DEBOUNCE_CYCLES+3 edges after key_n rises.
- Held key with mode_in toggled 01->11 between steps -> step_mode changes only on the edge that raises the next step.
- Release bounce: key_n high 2 cycles then low again while HELD -> no extra step, key_down stays 1.
- reset pulsed for 1 cycle during DB_PRESS with the key held -> outputs 0 after the reset edge; step reappears 7 edges after reset deasserts (DEBOUNCE_CYCLES=4).
